// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding scoreboard.
// TNEW_W lives here because the in-flight record type is sized by it.
package fwd_pkg;

  localparam int TNEW_W = 2;
  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int STG_E = 0;
  localparam int STG_M = 1;
  localparam int STG_W = 2;

  // Control part of an in-flight write; the captured result is kept alongside.
  typedef struct packed {
    logic              vld;
    logic [4:0]        dst;
    logic [TNEW_W-1:0] tnew;
    logic              rdy;
  } fwd_rec_t;

endpackage

// File: rtl/fwd_lookup.sv
// One D-stage read port: youngest-match forwarding select and load-use hazard compare.
module fwd_lookup
  import fwd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NSTG   = 3
) (
  input  logic [NSTG-1:0]        chn_vld,
  input  logic [NSTG-1:0]        chn_rdy,
  input  logic [NSTG*5-1:0]      chn_dst,
  input  logic [NSTG*TNEW_W-1:0] chn_tnew,
  input  logic [NSTG*DATA_W-1:0] chn_data,
  input  logic [NSTG-1:0]        res_vld,
  input  logic [NSTG*DATA_W-1:0] res_data,
  input  logic [4:0]             rd_addr,
  input  logic [TNEW_W-1:0]      rd_tuse,
  input  logic [DATA_W-1:0]      rf_rdata,
  output logic [DATA_W-1:0]      fwd_data,
  output logic                   hazard
);

  logic              hit;
  logic              src;
  logic [DATA_W-1:0] sel_data;
  logic [TNEW_W-1:0] win_tnew;

  // Walk oldest to youngest so the youngest matching stage overrides older ones.
  always_comb begin
    hit      = 1'b0;
    src      = 1'b0;
    sel_data = '0;
    win_tnew = '0;
    for (int s = NSTG - 1; s >= 0; s--) begin
      if (chn_vld[s] && (chn_dst[s*5 +: 5] == rd_addr)) begin
        hit      = 1'b1;
        win_tnew = chn_tnew[s*TNEW_W +: TNEW_W];
        if (chn_rdy[s]) begin
          src      = 1'b1;
          sel_data = chn_data[s*DATA_W +: DATA_W];
        end else if (res_vld[s]) begin
          src      = 1'b1;
          sel_data = res_data[s*DATA_W +: DATA_W];
        end else begin
          src      = 1'b0;
          sel_data = '0;
        end
      end
    end
  end

  always_comb begin
    fwd_data = rf_rdata;
    hazard   = 1'b0;
    if (rd_addr == REG_ZERO) begin
      fwd_data = '0;
    end else if (hit) begin
      fwd_data = src ? sel_data : rf_rdata;
      hazard   = !src && (win_tnew > rd_tuse);
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard scoreboard: shift chain of in-flight GPR writes from E to W.
// Optional FWD_STALL_CNT_EN adds a free-running count of stall cycles on stall_cnt.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NSTG   = 3,
  parameter int NRD    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iss_vld,
  input  logic [4:0]             iss_dst,
  input  logic [TNEW_W-1:0]      iss_tnew,
  input  logic [NSTG-1:0]        res_vld,
  input  logic [NSTG*DATA_W-1:0] res_data,
  input  logic [NRD*5-1:0]       rd_addr,
  input  logic [NRD*TNEW_W-1:0]  rd_tuse,
  input  logic [NRD*DATA_W-1:0]  rf_rdata,
  output logic [NRD*DATA_W-1:0]  fwd_data,
`ifdef FWD_STALL_CNT_EN
  output logic [31:0]            stall_cnt,
`endif
  output logic                   stall
);

  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  fwd_rec_t          rec_q  [NSTG];
  fwd_rec_t          rec_d  [NSTG];
  logic [DATA_W-1:0] data_q [NSTG];
  logic [DATA_W-1:0] data_d [NSTG];

  logic [NSTG-1:0]        chn_vld;
  logic [NSTG-1:0]        chn_rdy;
  logic [NSTG*5-1:0]      chn_dst;
  logic [NSTG*TNEW_W-1:0] chn_tnew;
  logic [NSTG*DATA_W-1:0] chn_data;
  logic [NRD-1:0]         hazard;

  // Stage 0 takes the issuing instruction (or a bubble while stalled); later
  // stages shift regardless of stall, so any stall drains within NSTG cycles.
  always_comb begin
    rec_d[0]  = '0;
    data_d[0] = '0;
    if (!stall && iss_vld && (iss_dst != REG_ZERO)) begin
      rec_d[0] = '{vld: 1'b1, dst: iss_dst, tnew: iss_tnew, rdy: 1'b0};
    end
    for (int s = 1; s < NSTG; s++) begin
      rec_d[s]      = rec_q[s-1];
      rec_d[s].tnew = tnew_dec(rec_q[s-1].tnew);
      data_d[s]     = data_q[s-1];
      if (res_vld[s-1] && rec_q[s-1].vld) begin
        rec_d[s].rdy = 1'b1;
        data_d[s]    = res_data[(s-1)*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NSTG; s++) begin
        rec_q[s]  <= '0;
        data_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NSTG; s++) begin
        rec_q[s]  <= rec_d[s];
        data_q[s] <= data_d[s];
      end
    end
  end

  always_comb begin
    chn_vld  = '0;
    chn_rdy  = '0;
    chn_dst  = '0;
    chn_tnew = '0;
    chn_data = '0;
    for (int s = 0; s < NSTG; s++) begin
      chn_vld[s]                    = rec_q[s].vld;
      chn_rdy[s]                    = rec_q[s].rdy;
      chn_dst[s*5 +: 5]             = rec_q[s].dst;
      chn_tnew[s*TNEW_W +: TNEW_W]  = rec_q[s].tnew;
      chn_data[s*DATA_W +: DATA_W]  = data_q[s];
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    fwd_lookup #(
      .DATA_W (DATA_W),
      .NSTG   (NSTG)
    ) u_lookup (
      .chn_vld  (chn_vld),
      .chn_rdy  (chn_rdy),
      .chn_dst  (chn_dst),
      .chn_tnew (chn_tnew),
      .chn_data (chn_data),
      .res_vld  (res_vld),
      .res_data (res_data),
      .rd_addr  (rd_addr[p*5 +: 5]),
      .rd_tuse  (rd_tuse[p*TNEW_W +: TNEW_W]),
      .rf_rdata (rf_rdata[p*DATA_W +: DATA_W]),
      .fwd_data (fwd_data[p*DATA_W +: DATA_W]),
      .hazard   (hazard[p])
    );
  end

  assign stall = |hazard;

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed, table-driven bench for fwd_scoreboard (two read ports, three tracked stages).
module tb_fwd_scoreboard;

  localparam logic [31:0] RF0 = 32'h1111_0000;
  localparam logic [31:0] RF1 = 32'h2222_0000;

  logic        clk;
  logic        reset;
  logic        iss_vld;
  logic [4:0]  iss_dst;
  logic [1:0]  iss_tnew;
  logic [2:0]  res_vld;
  logic [95:0] res_data;
  logic [9:0]  rd_addr;
  logic [3:0]  rd_tuse;
  logic [63:0] rf_rdata;
  logic [63:0] fwd_data;
  logic        stall;
`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  fwd_scoreboard #(.DATA_W(32), .NSTG(3), .NRD(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .iss_vld  (iss_vld),
    .iss_dst  (iss_dst),
    .iss_tnew (iss_tnew),
    .res_vld  (res_vld),
    .res_data (res_data),
    .rd_addr  (rd_addr),
    .rd_tuse  (rd_tuse),
    .rf_rdata (rf_rdata),
    .fwd_data (fwd_data),
`ifdef FWD_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .stall    (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        iv;
    logic [4:0]  id;
    logic [1:0]  it;
    logic [2:0]  rv;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  a0;
    logic [1:0]  tu0;
    logic [4:0]  a1;
    logic [1:0]  tu1;
    logic        es;
    logic        c0;
    logic [31:0] e0;
    logic        c1;
    logic [31:0] e1;
  } vec_t;

  vec_t vq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic row(input logic iv, input logic [4:0] id, input logic [1:0] it,
                     input logic [2:0] rv, input logic [31:0] d0, input logic [31:0] d1,
                     input logic [31:0] d2, input logic [4:0] a0, input logic [1:0] tu0,
                     input logic [4:0] a1, input logic [1:0] tu1, input logic es,
                     input logic c0, input logic [31:0] e0, input logic c1, input logic [31:0] e1);
    vec_t v;
    v.iv = iv;  v.id = id;  v.it = it;  v.rv = rv;
    v.d0 = d0;  v.d1 = d1;  v.d2 = d2;
    v.a0 = a0;  v.tu0 = tu0; v.a1 = a1; v.tu1 = tu1;
    v.es = es;  v.c0 = c0;  v.e0 = e0;  v.c1 = c1;  v.e1 = e1;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [4:0] id, input logic [1:0] it,
                       input logic [4:0] a0, input logic [1:0] tu0,
                       input logic [4:0] a1, input logic [1:0] tu1);
    iss_vld  = iv;
    iss_dst  = id;
    iss_tnew = it;
    res_vld  = 3'b000;
    res_data = '0;
    rd_addr  = {a1, a0};
    rd_tuse  = {tu1, tu0};
    rf_rdata = {RF1, RF0};
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);

    // iv id  it  rv      d0            d1            d2            a0  tu  a1  tu  stall c0 e0            c1 e1
    row(0, 0,  0, 3'b000, 0,            0,            0,            8,  0,  9,  0,  0,    1, RF0,          1, RF1);
    row(1, 8,  2, 3'b000, 0,            0,            0,            0,  0,  0,  0,  0,    1, 0,            1, 0);
    row(1, 11, 0, 3'b000, 0,            0,            0,            8,  0,  11, 0,  1,    0, 0,            1, RF1);
    row(1, 11, 0, 3'b000, 0,            0,            0,            8,  0,  11, 0,  1,    0, 0,            1, RF1);
    row(1, 11, 0, 3'b100, 0,            0,            32'hCAFEF00D, 8,  0,  11, 0,  0,    1, 32'hCAFEF00D, 1, RF1);
    row(1, 9,  1, 3'b001, 32'h5555,     0,            0,            8,  0,  11, 0,  0,    1, RF0,          1, 32'h5555);
    row(0, 0,  0, 3'b000, 0,            0,            0,            9,  1,  11, 0,  0,    0, 0,            1, 32'h5555);
    row(0, 0,  0, 3'b010, 0,            32'h1234,     0,            9,  0,  11, 0,  0,    1, 32'h1234,     1, 32'h5555);
    row(1, 10, 0, 3'b000, 0,            0,            0,            9,  0,  8,  0,  0,    1, 32'h1234,     1, RF1);
    row(1, 10, 0, 3'b001, 32'hAAAA,     0,            0,            10, 0,  9,  0,  0,    1, 32'hAAAA,     1, RF1);
    row(1, 10, 2, 3'b001, 32'hBBBB,     0,            0,            10, 0,  10, 3,  0,    1, 32'hBBBB,     1, 32'hBBBB);
    row(1, 0,  3, 3'b000, 0,            0,            0,            10, 0,  0,  0,  1,    0, 0,            1, 0);
    row(1, 0,  3, 3'b000, 0,            0,            0,            10, 1,  0,  0,  0,    0, 0,            1, 0);
    row(0, 0,  0, 3'b100, 0,            0,            32'h77,       0,  0,  10, 0,  0,    1, 0,            1, 32'h77);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].iv, vq[i].id, vq[i].it, vq[i].a0, vq[i].tu0, vq[i].a1, vq[i].tu1);
      res_vld  = vq[i].rv;
      res_data = {vq[i].d2, vq[i].d1, vq[i].d0};
      #1;
      chk("stall", i, {31'd0, stall}, {31'd0, vq[i].es});
      if (vq[i].c0) chk("fwd0", i, fwd_data[31:0], vq[i].e0);
      if (vq[i].c1) chk("fwd1", i, fwd_data[63:32], vq[i].e1);
      @(negedge clk);
    end
`ifdef FWD_STALL_CNT_EN
    chk("stall_cnt_table", 0, stall_cnt, 32'd3);
`endif

    // Reset while a load-use stall is active clears the chain.
    drive(1'b1, 5'd8, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 2'd0, 5'd8, 2'd0, 5'd8, 2'd0);
    #1;
    chk("rst_pre_stall", 0, {31'd0, stall}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_stall", 0, {31'd0, stall}, 32'd0);
    chk("rst_fwd0", 0, fwd_data[31:0], RF0);
    chk("rst_fwd1", 0, fwd_data[63:32], RF1);
`ifdef FWD_STALL_CNT_EN
    chk("rst_cnt", 0, stall_cnt, 32'd0);
`endif

    // tnew=3 with no result ever delivered: stalls in E, M and W, then retires.
    @(negedge clk);
    drive(1'b1, 5'd12, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 5'd0, 2'd0, 5'd12, 2'd0, 5'd0, 2'd0);
      #1;
      chk("lu_stall", c, {31'd0, stall}, (c < 3) ? 32'd1 : 32'd0);
      if (c >= 3) chk("lu_fwd0", c, fwd_data[31:0], RF0);
      @(negedge clk);
    end
`ifdef FWD_STALL_CNT_EN
    chk("stall_cnt_lu", 0, stall_cnt, 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
